// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first, one bit per clock, and
// reports the difference, unsigned borrow and two's-complement overflow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrowout,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            accept_c;
  logic            step_c;
  logic            last_c;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;

  logic             bit_a_c;
  logic             bit_b_c;
  logic             d_c;
  logic             borrow_next_c;
  logic [WIDTH-1:0] d_shifted_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    step_c     = 1'b0;
    last_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last_c     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One full-subtractor bit slice on the current LSBs
  always_comb begin
    bit_a_c       = a_sr[0];
    bit_b_c       = b_sr[0];
    d_c           = bit_a_c ^ bit_b_c ^ borrow;
    borrow_next_c = (~bit_a_c & bit_b_c) | (~(bit_a_c ^ bit_b_c) & borrow);
    d_shifted_c   = {d_c, d_sr[WIDTH-1:1]};
  end

  // Operand/result shift registers, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
      cnt        <= '0;
      borrow     <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
      difference <= '0;
      borrowout  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ready <= (state_next == IDLE);
      done  <= (state_next == DONE);
      if (accept_c) begin
        a_sr   <= a;
        b_sr   <= b;
        d_sr   <= '0;
        cnt    <= '0;
        borrow <= 1'b0;
      end else if (step_c) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        d_sr   <= d_shifted_c;
        borrow <= borrow_next_c;
        cnt    <= cnt + CW'(1);
      end
      // Publish on the final bit; the MSB operand bits sit in bit 0 now
      if (last_c) begin
        difference <= d_shifted_c;
        borrowout  <= borrow_next_c;
        overflow   <= (bit_a_c != bit_b_c) & (d_c != bit_a_c);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=32.
module tb_serial_subtractor;

  logic        clk;
  logic        reset;
  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        ready8;
  logic        done8;
  logic [7:0]  diff8;
  logic        bo8;
  logic        ov8;
  logic        start32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        ready32;
  logic        done32;
  logic [31:0] diff32;
  logic        bo32;
  logic        ov32;

  int checks;
  int errors;

  typedef struct {
    int          w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t vecs[8];

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .difference(diff8),
    .borrowout(bo8), .overflow(ov8)
  );

  serial_subtractor #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32),
    .ready(ready32), .done(done32), .difference(diff32),
    .borrowout(bo32), .overflow(ov32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    logic [63:0] one;
    one = 64'd1;
    return (w >= 64) ? '1 : ((one << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rnd(input int w);
    return {$urandom, $urandom} & wmask(w);
  endfunction

  // Reference: plain unsigned and signed integer arithmetic
  task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv,
                       output logic [63:0] df, output logic bo, output logic ov);
    longint sa;
    longint sb;
    longint t;
    longint lim;
    logic [63:0] m;
    m   = wmask(w);
    av  = av & m;
    bv  = bv & m;
    df  = (av - bv) & m;
    bo  = (av < bv);
    lim = longint'(1) << (w - 1);
    sa  = (av >= 64'(lim)) ? longint'(av) - 2 * lim : longint'(av);
    sb  = (bv >= 64'(lim)) ? longint'(bv) - 2 * lim : longint'(bv);
    t   = sa - sb;
    ov  = (t >= lim) || (t < -lim);
  endtask

  task automatic drive(input int w, input logic st, input logic [63:0] av, input logic [63:0] bv);
    if (w == 8) begin
      start8 = st; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start32 = st; a32 = av[31:0]; b32 = bv[31:0];
    end
  endtask

  task automatic sample(input int w, output logic rdy, output logic dn,
                        output logic [63:0] df, output logic bo, output logic ov);
    if (w == 8) begin
      rdy = ready8; dn = done8; df = 64'(diff8); bo = bo8; ov = ov8;
    end else begin
      rdy = ready32; dn = done32; df = 64'(diff32); bo = bo32; ov = ov32;
    end
  endtask

  // One operation from IDLE; returns results, latency in edges after accept,
  // whether outputs held during RUN, and whether ready came back after done.
  task automatic run_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                        input bit noise, output logic [63:0] df, output logic bo,
                        output logic ov, output int lat, output bit hold_ok,
                        output bit post_ok);
    logic        rdy, dn, b_s, o_s;
    logic [63:0] d_s, prev;
    sample(w, rdy, dn, prev, b_s, o_s);
    check("pre_ready", 64'(rdy), 64'd1);
    drive(w, 1'b1, av, bv);
    @(posedge clk); #1;
    if (noise) drive(w, 1'($urandom), rnd(w), rnd(w));
    else drive(w, 1'b0, av, bv);
    lat = -1; hold_ok = 1'b1; post_ok = 1'b0;
    df = '0; bo = 1'b0; ov = 1'b0;
    for (int n = 1; n <= 4 * w; n++) begin
      sample(w, rdy, dn, d_s, b_s, o_s);
      if (rdy !== 1'b0 || dn !== 1'b0 || d_s !== prev) hold_ok = 1'b0;
      @(posedge clk); #1;
      sample(w, rdy, dn, d_s, b_s, o_s);
      if (dn === 1'b1) begin
        lat = n; df = d_s; bo = b_s; ov = o_s;
        if (rdy !== 1'b0) hold_ok = 1'b0;
        drive(w, 1'b0, av, bv);
        break;
      end
      if (noise) drive(w, 1'($urandom), rnd(w), rnd(w));
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      sample(w, rdy, dn, d_s, b_s, o_s);
      post_ok = (rdy === 1'b1) && (dn === 1'b0) && (d_s === df);
    end
  endtask

  task automatic do_vec(input string tag, input int w, input logic [63:0] av,
                        input logic [63:0] bv, input logic [63:0] ed,
                        input logic ebo, input logic eov, input bit noise);
    logic [63:0] df;
    logic        bo, ov;
    int          lat;
    bit          hold_ok, post_ok;
    run_op(w, av, bv, noise, df, bo, ov, lat, hold_ok, post_ok);
    check({tag, " latency"}, 64'(lat), 64'(w));
    check({tag, " difference"}, df, ed);
    check({tag, " borrowout"}, 64'(bo), 64'(ebo));
    check({tag, " overflow"}, 64'(ov), 64'(eov));
    check({tag, " hold_during_run"}, 64'(hold_ok), 64'd1);
    check({tag, " ready_after_done"}, 64'(post_ok), 64'd1);
  endtask

  initial begin
    logic [63:0] ed, av, bv, df;
    logic        ebo, eov, rdy, dn, bo, ov;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    int          q_c[$];
    int          last_done, n_res, acc, waited;
    logic [15:0] ea, eb;

    checks = 0;
    errors = 0;

    vecs[0] = '{8,  64'h25,       64'h13,       64'h12,       1'b0, 1'b0};
    vecs[1] = '{8,  64'h10,       64'h20,       64'hF0,       1'b1, 1'b0};
    vecs[2] = '{8,  64'h80,       64'h01,       64'h7F,       1'b0, 1'b1};
    vecs[3] = '{8,  64'h7F,       64'h80,       64'hFF,       1'b1, 1'b1};
    vecs[4] = '{8,  64'h00,       64'hFF,       64'h01,       1'b1, 1'b0};
    vecs[5] = '{32, 64'h00000000, 64'h00000001, 64'hFFFFFFFF, 1'b1, 1'b0};
    vecs[6] = '{32, 64'h7FFFFFFF, 64'hFFFFFFFF, 64'h80000000, 1'b1, 1'b1};
    vecs[7] = '{32, 64'h80000000, 64'h00000001, 64'h7FFFFFFF, 1'b0, 1'b1};

    reset = 1'b1;
    drive(8, 1'b1, 64'hAA, 64'h55);
    drive(32, 1'b1, 64'hAA, 64'h55);
    repeat (2) @(posedge clk);
    #1;
    check("reset ready8", 64'(ready8), 64'd1);
    check("reset done8", 64'(done8), 64'd0);
    check("reset outputs8", {53'd0, diff8, bo8, ov8, done8}, 64'd0);
    check("reset ready32", 64'(ready32), 64'd1);
    check("reset outputs32", {29'd0, diff32, bo32, ov32, done32}, 64'd0);
    drive(8, 1'b0, 64'd0, 64'd0);
    drive(32, 1'b0, 64'd0, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i])
      do_vec($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].b,
             vecs[i].d, vecs[i].bo, vecs[i].ov, 1'b0);

    // start held high, operands changing every cycle
    last_done = -1; n_res = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      av = rnd(8); bv = rnd(8);
      drive(8, 1'b1, av, bv);
      rdy = ready8;
      @(posedge clk);
      if (rdy) begin
        q_a.push_back(av[15:0]); q_b.push_back(bv[15:0]); q_c.push_back(cyc);
      end
      #1;
      if (done8) begin
        n_res++;
        if (q_a.size() == 0) begin
          check("b2b unexpected done", 64'd1, 64'd0);
        end else begin
          ea = q_a.pop_front(); eb = q_b.pop_front(); acc = q_c.pop_front();
          model(8, 64'(ea), 64'(eb), ed, ebo, eov);
          check("b2b difference", 64'(diff8), ed);
          check("b2b borrowout", 64'(bo8), 64'(ebo));
          check("b2b overflow", 64'(ov8), 64'(eov));
          check("b2b latency", 64'(cyc - acc), 64'd8);
        end
        if (last_done >= 0) check("b2b period", 64'(cyc - last_done), 64'd10);
        last_done = cyc;
      end
    end
    drive(8, 1'b0, 64'd0, 64'd0);
    check("b2b result count", 64'(n_res), 64'd6);
    check("b2b queue empty", 64'(q_a.size()), 64'd0);
    waited = 0;
    while (ready8 !== 1'b1 && waited < 30) begin
      @(posedge clk); #1; waited++;
    end
    check("b2b idle", 64'(ready8), 64'd1);

    // Asynchronous reset in the middle of RUN
    drive(8, 1'b1, 64'h37, 64'h11);
    @(posedge clk); #1;
    drive(8, 1'b0, 64'h37, 64'h11);
    repeat (3) @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async reset ready", 64'(ready8), 64'd1);
    check("async reset outputs", {53'd0, diff8, bo8, ov8, done8}, 64'd0);
    drive(8, 1'b1, 64'h99, 64'h11);
    @(posedge clk); #1;
    check("start ignored in reset", {62'd0, ready8, done8}, 64'h2);
    reset = 1'b0;
    drive(8, 1'b0, 64'd0, 64'd0);
    n_res = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 !== 1'b0 || ready8 !== 1'b1) n_res++;
    end
    check("no done after abort", 64'(n_res), 64'd0);
    do_vec("after reset", 8, 64'h05, 64'h05, 64'h00, 1'b0, 1'b0, 1'b0);

    // Randomized against the reference model, with noise on inputs during RUN
    for (int i = 0; i < 1500; i++) begin
      av = rnd(8); bv = rnd(8);
      model(8, av, bv, ed, ebo, eov);
      do_vec("rand8", 8, av, bv, ed, ebo, eov, 1'b1);
    end
    for (int i = 0; i < 600; i++) begin
      av = rnd(32); bv = rnd(32);
      if (i < 8) bv = av ^ (64'd1 << (31 - i));
      model(32, av, bv, ed, ebo, eov);
      do_vec("rand32", 32, av, bv, ed, ebo, eov, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
